// File: rtl/qpsk_tx_pkg.sv
// Shared types and constants for the QPSK transmit modulator.
// State encodings are plain constants so dbg_state matches legacy tooling.
package qpsk_tx_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] dibit_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_PREAMBLE = 2'd1;
    localparam state_t ST_PAYLOAD  = 2'd2;
    localparam state_t ST_TAIL     = 2'd3;

    // Gray constellation points, named by the sign of I then Q
    localparam dibit_t GRAY_PP = 2'b00;
    localparam dibit_t GRAY_MP = 2'b01;
    localparam dibit_t GRAY_MM = 2'b11;
    localparam dibit_t GRAY_PM = 2'b10;

    localparam dibit_t PREAMBLE_EVEN = 2'b00;
    localparam dibit_t PREAMBLE_ODD  = 2'b11;

endpackage

// File: rtl/qpsk_gray_mapper.sv
// Combinational Gray mapper: dibit to signed I/Q at +/-AMP.
// The zero input forces the (0,0) point used for underrun and tail symbols.
module qpsk_gray_mapper
    import qpsk_tx_pkg::*;
#(
    parameter logic signed [15:0] AMP = 16'sd11585
) (
    input  logic [1:0]         dibit,
    input  logic               zero,
    output logic signed [15:0] sig_i,
    output logic signed [15:0] sig_q
);

    localparam logic signed [15:0] NEG_AMP = -AMP;

    always_comb begin
        sig_i = AMP;
        sig_q = AMP;
        if (zero) begin
            sig_i = '0;
            sig_q = '0;
        end else begin
            case (dibit)
                GRAY_PP: begin sig_i = AMP;     sig_q = AMP;     end
                GRAY_MP: begin sig_i = NEG_AMP; sig_q = AMP;     end
                GRAY_MM: begin sig_i = NEG_AMP; sig_q = NEG_AMP; end
                GRAY_PM: begin sig_i = AMP;     sig_q = NEG_AMP; end
                default: begin sig_i = AMP;     sig_q = AMP;     end
            endcase
        end
    end

endmodule

// File: rtl/qpsk_tx_mod.sv
// QPSK baseband modulator: frames bytes as preamble, payload and zero tail,
// holding each Gray-mapped symbol for SPS strobed samples.
module qpsk_tx_mod
    import qpsk_tx_pkg::*;
#(
    parameter int                SPS          = 4,
    parameter int                PREAMBLE_LEN = 32,
    parameter int                TAIL_LEN     = 8,
    parameter logic signed [15:0] AMP         = 16'sd11585
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_smp_en,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic        o_vld,
    output logic [15:0] o_signal_i,
    output logic [15:0] o_signal_q,
    output logic        o_busy,
    output logic        o_underrun,
    output logic [1:0]  dbg_state
);

    localparam logic [3:0] SMP_LAST  = 4'(SPS - 1);
    localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] TAIL_LAST = 8'(TAIL_LEN - 1);

    state_t     state;
    logic [3:0] smp_cnt;
    logic [7:0] sym_cnt;
    logic [1:0] dibit_idx;
    logic [7:0] shreg;
    logic       cur_zero;
    logic       last_loaded;
    logic [7:0] hold_data;
    logic       hold_last;
    logic       hold_vld;

    logic               accept;
    logic               boundary;
    logic               need_byte;
    logic               sym_zero;
    dibit_t             sym_dibit;
    logic signed [15:0] map_i;
    logic signed [15:0] map_q;

    assign s_tready  = !hold_vld && (state != ST_TAIL) && !((state == ST_PAYLOAD) && last_loaded);
    assign accept    = s_tvalid && s_tready;
    assign boundary  = i_smp_en && (state != ST_IDLE) && (smp_cnt == SMP_LAST);
    assign o_busy    = (state != ST_IDLE);
    assign dbg_state = state;

    // A byte is due when the preamble ends, after the 4th dibit of a
    // non-final byte, or after an underrun symbol (retry).
    always_comb begin
        need_byte = 1'b0;
        if (boundary) begin
            if (state == ST_PREAMBLE)
                need_byte = (sym_cnt == PRE_LAST);
            else if (state == ST_PAYLOAD)
                need_byte = cur_zero || ((dibit_idx == 2'd3) && !last_loaded);
        end
    end

    always_comb begin
        sym_dibit = PREAMBLE_EVEN;
        sym_zero  = 1'b1;
        case (state)
            ST_PREAMBLE: begin
                sym_dibit = sym_cnt[0] ? PREAMBLE_ODD : PREAMBLE_EVEN;
                sym_zero  = 1'b0;
            end
            ST_PAYLOAD: begin
                sym_dibit = shreg[7:6];
                sym_zero  = cur_zero;
            end
            default: ;
        endcase
    end

    qpsk_gray_mapper #(
        .AMP(AMP)
    ) u_mapper (
        .dibit(sym_dibit),
        .zero (sym_zero),
        .sig_i(map_i),
        .sig_q(map_q)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            smp_cnt     <= '0;
            sym_cnt     <= '0;
            dibit_idx   <= '0;
            shreg       <= '0;
            cur_zero    <= 1'b0;
            last_loaded <= 1'b0;
        end else begin
            if (i_smp_en && (state != ST_IDLE))
                smp_cnt <= boundary ? 4'd0 : smp_cnt + 4'd1;
            if (need_byte) begin
                dibit_idx <= '0;
                cur_zero  <= !hold_vld;
                if (hold_vld) begin
                    shreg       <= hold_data;
                    last_loaded <= hold_last;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_PREAMBLE;
                        smp_cnt <= '0;
                        sym_cnt <= '0;
                    end
                end
                ST_PREAMBLE: begin
                    if (boundary) begin
                        if (sym_cnt == PRE_LAST) begin
                            state   <= ST_PAYLOAD;
                            sym_cnt <= '0;
                        end else begin
                            sym_cnt <= sym_cnt + 8'd1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (boundary && !need_byte) begin
                        if (dibit_idx == 2'd3) begin
                            state       <= ST_TAIL;
                            sym_cnt     <= '0;
                            last_loaded <= 1'b0;
                        end else begin
                            shreg     <= {shreg[5:0], 2'b00};
                            dibit_idx <= dibit_idx + 2'd1;
                        end
                    end
                end
                default: begin
                    if (boundary) begin
                        if (sym_cnt == TAIL_LAST)
                            state <= ST_IDLE;
                        else
                            sym_cnt <= sym_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_data <= '0;
            hold_last <= 1'b0;
            hold_vld  <= 1'b0;
        end else if (accept) begin
            hold_data <= s_tdata;
            hold_last <= s_tlast;
            hold_vld  <= 1'b1;
        end else if (need_byte && hold_vld) begin
            hold_vld <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vld      <= 1'b0;
            o_signal_i <= '0;
            o_signal_q <= '0;
            o_underrun <= 1'b0;
        end else begin
            o_underrun <= need_byte && !hold_vld;
            if (state == ST_IDLE) begin
                o_vld      <= 1'b0;
                o_signal_i <= '0;
                o_signal_q <= '0;
            end else if (i_smp_en) begin
                o_vld      <= 1'b1;
                o_signal_i <= map_i;
                o_signal_q <= map_q;
            end else begin
                o_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qpsk_tx_mod.sv
// Bench for qpsk_tx_mod: a table of single-byte frames plus hand-written
// back-to-back, underrun, mid-frame reset and short-parameter sequences.
`timescale 1ns/1ps
module tb_qpsk_tx_mod;

    localparam logic signed [15:0] A  = 16'sd11585;
    localparam logic signed [15:0] NA = -16'sd11585;

    typedef struct packed {
        logic [7:0]       data;
        logic [3:0]       period;
        logic [3:0][15:0] exp_i;
        logic [3:0][15:0] exp_q;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        smp_en = 1'b0;
    logic [7:0]  tdata = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        tready, vld, busy, underrun;
    logic [15:0] sig_i, sig_q;
    logic [1:0]  state;
    logic [7:0]  tdata_b = '0;
    logic        tvalid_b = 1'b0;
    logic        tlast_b = 1'b0;
    logic        tready_b, vld_b, busy_b, underrun_b;
    logic [15:0] sig_i_b, sig_q_b;
    logic [1:0]  state_b;

    int          checks = 0;
    int          errors = 0;
    int          period = 1;
    int          phase = 0;
    int          ur_cnt = 0;
    logic        smp_prev = 1'b0;
    logic [31:0] got_a[$];
    logic [31:0] got_b[$];
    logic [31:0] exp_s[$];
    vec_t        vecs[5];

    qpsk_tx_mod dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_smp_en(smp_en),
        .s_tdata(tdata), .s_tvalid(tvalid), .s_tlast(tlast), .s_tready(tready),
        .o_vld(vld), .o_signal_i(sig_i), .o_signal_q(sig_q),
        .o_busy(busy), .o_underrun(underrun), .dbg_state(state)
    );

    qpsk_tx_mod #(.SPS(2), .PREAMBLE_LEN(1), .TAIL_LEN(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_smp_en(smp_en),
        .s_tdata(tdata_b), .s_tvalid(tvalid_b), .s_tlast(tlast_b), .s_tready(tready_b),
        .o_vld(vld_b), .o_signal_i(sig_i_b), .o_signal_q(sig_q_b),
        .o_busy(busy_b), .o_underrun(underrun_b), .dbg_state(state_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] gray(input logic [1:0] d);
        case (d)
            2'b00:   return {A, A};
            2'b01:   return {NA, A};
            2'b11:   return {NA, NA};
            default: return {A, NA};
        endcase
    endfunction

    task automatic push_sym(input logic [31:0] s, input int sps);
        for (int k = 0; k < sps; k++) exp_s.push_back(s);
    endtask

    task automatic push_preamble(input int sps, input int len);
        for (int k = 0; k < len; k++) push_sym((k % 2 == 0) ? {A, A} : {NA, NA}, sps);
    endtask

    task automatic push_byte(input logic [7:0] b, input int sps);
        logic [7:0] sh;
        sh = b;
        for (int k = 0; k < 4; k++) begin
            push_sym(gray(sh[7:6]), sps);
            sh = {sh[5:0], 2'b00};
        end
    endtask

    task automatic compare_stream(input string name, input bit use_b);
        logic [31:0] g[$];
        int          e0;
        if (use_b) g = got_b; else g = got_a;
        checkOutput({name, "_count"}, 32'(g.size()), 32'(exp_s.size()));
        e0 = errors;
        for (int k = 0; k < g.size() && k < exp_s.size(); k++) begin
            checkOutput($sformatf("%s_sample%0d", name, k), g[k], exp_s[k]);
            if (errors != e0) break;
        end
    endtask

    // Offer one byte and return just after the accepting edge; valid stays high
    task automatic applyStimulus(input bit use_b, input logic [7:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        if (use_b) begin tdata_b = d; tlast_b = l; tvalid_b = 1'b1; end
        else       begin tdata = d;   tlast = l;   tvalid = 1'b1;   end
        while (!(use_b ? tready_b : tready) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_timeout", 32'(use_b ? tready_b : tready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input bit use_b, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((use_b ? busy_b : busy) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_idle_timeout"}, 32'(use_b ? busy_b : busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (period <= 1) smp_en = 1'b1;
            else begin
                phase  = (phase + 1) % period;
                smp_en = (phase == 0);
            end
        end
    end

    always @(posedge clk) smp_prev <= smp_en;

    // Outputs sampled mid-cycle; a valid sample with no strobe before it is an error
    always @(negedge clk) begin
        if (vld)      got_a.push_back({sig_i, sig_q});
        if (vld_b)    got_b.push_back({sig_i_b, sig_q_b});
        if (underrun) ur_cnt++;
        if (rst_n && !smp_prev) checkOutput("vld_after_gap", 32'(vld), 32'd0);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        vecs[0] = {8'h1B, 4'd1, {A, NA, A, NA},  {A, A, NA, NA}};
        vecs[1] = {8'h1B, 4'd3, {A, NA, A, NA},  {A, A, NA, NA}};
        vecs[2] = {8'hE4, 4'd1, {NA, A, NA, A},  {NA, NA, A, A}};
        vecs[3] = {8'h36, 4'd2, {A, NA, NA, A},  {A, NA, A, NA}};
        vecs[4] = {8'hC9, 4'd1, {NA, A, A, NA},  {NA, A, NA, A}};

        repeat (3) @(negedge clk);
        checkOutput("rst_vld",    32'(vld),      32'd0);
        checkOutput("rst_i",      32'(sig_i),    32'd0);
        checkOutput("rst_q",      32'(sig_q),    32'd0);
        checkOutput("rst_busy",   32'(busy),     32'd0);
        checkOutput("rst_ur",     32'(underrun), 32'd0);
        checkOutput("rst_tready", 32'(tready),   32'd1);
        checkOutput("rst_state",  32'(state),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            period = int'(vecs[v].period);
            got_a.delete();
            exp_s.delete();
            ur_cnt = 0;
            applyStimulus(1'b0, vecs[v].data, 1'b1);
            @(negedge clk);
            tvalid = 1'b0;
            wait_idle(1'b0, $sformatf("vec%0d", v));
            push_preamble(4, 32);
            for (int k = 0; k < 4; k++) push_sym({vecs[v].exp_i[3-k], vecs[v].exp_q[3-k]}, 4);
            push_sym(32'd0, 32);
            compare_stream($sformatf("vec%0d", v), 1'b0);
            checkOutput($sformatf("vec%0d_underruns", v), 32'(ur_cnt), 32'd0);
            checkOutput($sformatf("vec%0d_tready_idle", v), 32'(tready), 32'd1);
        end
        period = 1;

        got_a.delete();
        exp_s.delete();
        ur_cnt = 0;
        applyStimulus(1'b0, 8'hFF, 1'b0);
        @(negedge clk);
        tdata = 8'h00;
        repeat (20) @(negedge clk);
        checkOutput("b2b_tready_hold_full", 32'(tready), 32'd0);
        checkOutput("b2b_state_preamble",   32'(state),  32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'hAA, 1'b1);
        @(negedge clk);
        tvalid = 1'b0;
        n = 0;
        while (state == 2'd2 && n < 200) begin
            checkOutput("b2b_tready_after_last", 32'(tready), 32'd0);
            if (tready) break;
            @(negedge clk);
            n++;
        end
        wait_idle(1'b0, "b2b");
        push_preamble(4, 32);
        push_byte(8'hFF, 4);
        push_byte(8'h00, 4);
        push_byte(8'hAA, 4);
        push_sym(32'd0, 32);
        compare_stream("b2b", 1'b0);
        checkOutput("b2b_underruns", 32'(ur_cnt), 32'd0);

        got_a.delete();
        exp_s.delete();
        ur_cnt = 0;
        applyStimulus(1'b0, 8'h1B, 1'b0);
        @(negedge clk);
        tvalid = 1'b0;
        n = 0;
        while (ur_cnt < 6 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("ur_wait", 32'(ur_cnt), 32'd6);
        applyStimulus(1'b0, 8'hE4, 1'b1);
        @(negedge clk);
        tvalid = 1'b0;
        wait_idle(1'b0, "ur");
        push_preamble(4, 32);
        push_byte(8'h1B, 4);
        push_sym(32'd0, 24);
        push_byte(8'hE4, 4);
        push_sym(32'd0, 32);
        compare_stream("ur", 1'b0);
        checkOutput("ur_total", 32'(ur_cnt), 32'd6);

        applyStimulus(1'b0, 8'h1B, 1'b1);
        @(negedge clk);
        tvalid = 1'b0;
        n = 0;
        while (state != 2'd2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_vld",    32'(vld),    32'd0);
        checkOutput("arst_i",      32'(sig_i),  32'd0);
        checkOutput("arst_q",      32'(sig_q),  32'd0);
        checkOutput("arst_tready", 32'(tready), 32'd1);
        checkOutput("arst_busy",   32'(busy),   32'd0);
        checkOutput("arst_state",  32'(state),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        got_a.delete();
        exp_s.delete();
        ur_cnt = 0;
        applyStimulus(1'b0, 8'hC9, 1'b1);
        @(negedge clk);
        tvalid = 1'b0;
        wait_idle(1'b0, "post_rst");
        push_preamble(4, 32);
        push_byte(8'hC9, 4);
        push_sym(32'd0, 32);
        compare_stream("post_rst", 1'b0);

        got_b.delete();
        exp_s.delete();
        applyStimulus(1'b1, 8'hE4, 1'b1);
        @(negedge clk);
        tvalid_b = 1'b0;
        wait_idle(1'b1, "sps2");
        push_sym({A, A}, 2);
        push_sym({NA, NA}, 2);
        push_sym({A, NA}, 2);
        push_sym({NA, A}, 2);
        push_sym({A, A}, 2);
        push_sym(32'd0, 2);
        compare_stream("sps2", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qpsk_tx_mod.md
Name: qpsk_tx_mod

Overview:
QPSK baseband modulator. It is the transmit-side counterpart to the QPSK carrier-recovery PLL. It accepts payload bytes over an AXI-Stream-style handshake and frames them as preamble, payload and flush tail. Each dibit is Gray-mapped to a signed 16-bit I/Q pair, held for SPS samples (rectangular), and the samples feed the external pulse-shaping filter and DAC path.

Parameters:
SPS, 4, samples per symbol (2..16)
PREAMBLE_LEN, 32, preamble symbols (1..255), alternating symbol 00 / symbol 11, starting with 00
TAIL_LEN, 8, flush symbols of (0,0) after last payload symbol (1..255)
AMP, 16'sd11585, signed per-axis constellation magnitude

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_smp_en  in  1  sample strobe; one output sample per strobe
s_tdata  in  8  payload byte; dibit [7:6] is sent first, [1:0] last
s_tvalid  in  1  byte valid
s_tlast  in  1  marks final byte of frame
s_tready  out  1  byte accepted when s_tvalid&&s_tready at rising edge
o_vld  out  1  output sample valid
o_signal_i  out  16  signed in-phase sample
o_signal_q  out  16  signed quadrature sample
o_busy  out  1  high when state != IDLE
o_underrun  out  1  one-cycle pulse on payload starvation
dbg_state  out  2  current state encoding

Behaviour:
- Clock and reset: one clock, i_clk. Reset is i_rst_n, asynchronous and active-low. Reset clears all state: IDLE, counters 0, hold buffer empty, o_vld=0, o_signal_i=o_signal_q=0, o_busy=0, o_underrun=0. Reset mid-frame aborts the frame with no tail.
- Hold buffer: one byte plus its last flag.
  - s_tready = !hold_vld && state!=TAIL && !(state==PAYLOAD && last_loaded).
  - last_loaded is set when a last byte moves into the shift register.
- Shift register: loaded from the hold buffer when a symbol boundary in PAYLOAD needs a new byte. That load frees the hold buffer in the same cycle.
- Sample timing:
  - smp_cnt runs 0..SPS-1 and advances only on i_smp_en in a non-IDLE state.
  - A symbol boundary is i_smp_en with smp_cnt==SPS-1.
  - Outputs are registered. On i_smp_en in a non-IDLE state, the current symbol's I/Q is registered and o_vld is asserted the next cycle for exactly one cycle.
  - Latency from strobe to o_vld is one cycle.
- State IDLE (encoding 0):
  - Outputs are zero and o_vld=0.
  - The first accepted byte goes to the hold buffer and moves the state to PREAMBLE with smp_cnt=0 and sym_cnt=0.
- State PREAMBLE (1):
  - Symbol at sym_cnt is 00 when sym_cnt is even and 11 when odd.
  - After PREAMBLE_LEN symbol boundaries, go to PAYLOAD.
- State PAYLOAD (2):
  - Each symbol consumes one dibit, MSB first. Every 4 symbols a new byte is needed.
  - If the hold buffer is empty at the byte boundary: emit a (0,0) symbol, pulse o_underrun for one cycle, stay in PAYLOAD, and retry at the next boundary.
  - After the 4th dibit of the last byte, go to TAIL.
- State TAIL (3): emit (0,0) for TAIL_LEN symbols, then go to IDLE. o_busy drops the same cycle the state returns to IDLE.
- Gray map (b1b0 -> I,Q):
  - 00 -> (+AMP,+AMP)
  - 01 -> (-AMP,+AMP)
  - 11 -> (-AMP,-AMP)
  - 10 -> (+AMP,-AMP)
  - -AMP is the exact two's-complement negation; no saturation is needed for the legal AMP range.
- Simultaneous events:
  - A byte accept and a shift-register load from the hold buffer in the same cycle is legal. The freed slot is not re-offered until the next cycle, because s_tready is registered-free combinational on hold_vld.
  - A strobe arriving on the last TAIL boundary together with a new byte: the byte is not accepted until IDLE.
- i_smp_en gaps of any length are allowed. Between strobes, state and outputs hold except o_vld=0.

Decomposition:
- Package qpsk_tx_pkg:
  - state enum IDLE/PREAMBLE/PAYLOAD/TAIL (2-bit)
  - dibit type
  - Gray map constants
  - preamble dibit constants 2'b00 / 2'b11
- Sub-module qpsk_gray_mapper: combinational, dibit + AMP -> signed I/Q, with a zero-force input. The remaining framing, handshake and counters stay in qpsk_tx_mod.

Test Plan:
- Default parameters, i_smp_en held high, one byte 0x1B with tlast.
  - Expect 32 preamble symbols × 4 samples alternating (11585,11585)/(-11585,-11585).
  - Then 4-sample runs of (11585,11585), (-11585,11585), (11585,-11585), (-11585,-11585).
  - Then 32 samples of (0,0), then o_busy=0. Total o_vld count is 176.
- Three bytes 0xFF,0x00,0xAA (last on 0xAA), s_tvalid always high.
  - Expect 12 contiguous payload symbols with no underrun.
  - s_tready low while the hold buffer is full.
- Two bytes with the second delayed by 10 symbols: o_underrun pulses 6 times, with (0,0) symbols inserted between the bytes.
- i_smp_en asserted every 3rd cycle: o_vld is a 1-cycle pulse one cycle after each strobe, and the sample sequence is identical to the first scenario.
- Assert i_rst_n=0 asynchronously mid-payload: outputs zero immediately and s_tready=1. A new frame after release starts cleanly with the preamble.
- SPS=2, PREAMBLE_LEN=1, TAIL_LEN=1, byte 0xE4:
  - Samples are (+A,+A)×2 for the preamble.
  - Then dibits 11,10,01,00, each ×2.
  - Then (0,0)×2.
